dense_layer_engine: RTL

//  Time-multiplexed fully-connected layer: y[n] = sat(sum_k x[k]*W[n][k] + b[n]) for n<N_OUT, k<N_IN.

---
 rtl/dense_layer_pkg.sv | 47 ++++
 rtl/dense_layer_engine_mac_lane.sv | 62 ++++++
 rtl/dense_layer_engine.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_pkg.sv
// Package: dense_layer_pkg
// Shared types and helpers for the time-multiplexed dense layer engine.
//   state_e : engine FSM states (IDLE, LOAD, MAC, DRAIN, OUT, FIN)
//   acc_w   : accumulator width that cannot overflow for N_IN products of DW x DW
//   cw      : address/index width, at least 1 bit
//   sat     : clamp a sign-extended accumulator to the signed DW range
// Optional feature macro used by the engine: DENSE_RELU_EN.
package dense_layer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4,
        FIN   = 3'd5
    } state_e;

    // Working width of sat(); accumulators are sign-extended to this before clamping.
    localparam int SAT_W = 64;

    function automatic int acc_w(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in) + 1;
    endfunction

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Result is the clamped value, still sign-extended to SAT_W; callers keep the low dw bits.
    function automatic logic [SAT_W-1:0] sat(input logic [SAT_W-1:0] acc, input int dw);
        logic signed [SAT_W-1:0] a;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        a  = signed'(acc);
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (a > hi) begin
            return hi;
        end
        if (a < lo) begin
            return lo;
        end
        return a;
    endfunction

endpackage

// File: rtl/dense_layer_engine_mac_lane.sv
// Module: dense_mac_lane
// One shared MAC lane: accumulates x*w products (DW x DW signed, sign-extended)
// and a bias term into an ACC_W-bit register.
//   clear    : zero the accumulator (wins over en/bias_add)
//   en       : add x*w this cycle
//   bias_add : add sign-extended bias this cycle (once per neuron group)
//   acc      : current accumulator value
module dense_mac_lane #(
    parameter int DW    = 16,
    parameter int ACC_W = 39
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DW-1:0]    x,
    input  logic [DW-1:0]    w,
    input  logic             bias_add,
    input  logic [DW-1:0]    bias,
    output logic [ACC_W-1:0] acc
);

    logic [2*DW-1:0]  xs;
    logic [2*DW-1:0]  ws;
    logic [2*DW-1:0]  prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] bias_ext;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;

    always_comb begin
        // Sign-extend both operands to 2*DW; the low 2*DW bits of the product
        // are then the exact signed product.
        xs       = {{DW{x[DW-1]}}, x};
        ws       = {{DW{w[DW-1]}}, w};
        prod     = xs * ws;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias};
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else begin
            if (en) begin
                acc_d = acc_d + prod_ext;
            end
            if (bias_add) begin
                acc_d = acc_d + bias_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dense_layer_engine.sv
// Module: dense_layer_engine
// Time-multiplexed fully-connected layer y[n] = sat(sum_k x[k]*W[n][k] + b[n]).
// LANES shared MAC lanes compute one neuron group g (neurons g*LANES..g*LANES+LANES-1)
// at a time; the input vector is buffered once and replayed for every group.
// Ports:
//   start                        : begin a pass (only honoured in IDLE)
//   in_valid/in_ready/in_data    : input vector stream, x[0..N_IN-1] in order
//   w_rd_en/w_addr/w_rdata       : weight ROM, data one cycle after w_rd_en, address g*N_IN+k
//   b_addr/b_rdata               : bias ROM word g, valid one cycle after first read of the group
//   out_valid/out_ready/out_data/out_idx : result stream, one neuron per beat
//   busy                         : engine not IDLE
//   done                         : one-cycle pulse after the final beat is taken
// Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
// a source holds valid and its payload unchanged until that edge.
// Build option: define DENSE_RELU_EN to clamp negative results to 0 after saturation.
module dense_layer_engine
    import dense_layer_pkg::*;
#(
    parameter int  DW       = 16,
    parameter int  N_IN     = 64,
    parameter int  N_OUT    = 128,
    parameter int  LANES    = 8,
    localparam int G        = N_OUT / LANES,
    localparam int W_ADDR_W = cw(N_IN * G),
    localparam int B_ADDR_W = cw(G),
    localparam int IDX_W    = cw(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  w_rd_en,
    output logic [W_ADDR_W-1:0]   w_addr,
    input  logic [LANES*DW-1:0]   w_rdata,
    output logic [B_ADDR_W-1:0]   b_addr,
    input  logic [LANES*DW-1:0]   b_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int K_W   = cw(N_IN);
    localparam int L_W   = cw(LANES);
    localparam int ACC_W = acc_w(DW, N_IN);

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [B_ADDR_W-1:0]  g_q, g_d;
    logic [L_W-1:0]       l_q, l_d;
    logic [L_W-1:0]       l_inc;
    logic [K_W-1:0]       k_rd_q, k_rd_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 in_ready_q, in_ready_d;
    logic                 w_rd_en_q, w_rd_en_d;
    logic [W_ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic                 out_valid_q, out_valid_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic                 done_q, done_d;
    logic [DW-1:0]        x_buf_q [N_IN];
    logic [DW-1:0]        x_buf_d [N_IN];

    logic                 acc_clear;
    logic                 bias_add;
    logic [DW-1:0]        x_cur;
    logic [ACC_W-1:0]     acc    [LANES];
    logic [DW-1:0]        y_lane [LANES];

    function automatic logic [IDX_W-1:0] idx_of(input logic [B_ADDR_W-1:0] g,
                                                input logic [L_W-1:0] l);
        return IDX_W'(int'(g) * LANES + int'(l));
    endfunction

    // rd_vld_q/k_rd_q track the read issued last cycle, whose ROM data is on
    // w_rdata now. The bias arrives with the first read of the group.
    assign x_cur    = x_buf_q[k_rd_q];
    assign bias_add = rd_vld_q && (k_rd_q == '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dense_mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (acc_clear),
            .en       (rd_vld_q),
            .x        (x_cur),
            .w        (w_rdata[l*DW +: DW]),
            .bias_add (bias_add),
            .bias     (b_rdata[l*DW +: DW]),
            .acc      (acc[l])
        );
    end

    // Saturate (and optionally rectify) every lane result.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            y_lane[l] = DW'(sat({{(SAT_W-ACC_W){acc[l][ACC_W-1]}}, acc[l]}, DW));
`ifdef DENSE_RELU_EN
            if (y_lane[l][DW-1]) begin
                y_lane[l] = '0;
            end
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        g_d         = g_q;
        l_d         = l_q;
        l_inc       = l_q + L_W'(1);
        k_rd_d      = k_q;
        rd_vld_d    = w_rd_en_q;
        in_ready_d  = in_ready_q;
        w_rd_en_d   = w_rd_en_q;
        w_addr_d    = w_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        acc_clear   = 1'b0;
        x_buf_d     = x_buf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    in_ready_d = 1'b1;
                    k_d        = '0;
                    g_d        = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    x_buf_d[k_q] = in_data;
                    if (k_q == K_W'(N_IN - 1)) begin
                        state_d    = MAC;
                        in_ready_d = 1'b0;
                        acc_clear  = 1'b1;
                        k_d        = '0;
                        w_rd_en_d  = 1'b1;
                        w_addr_d   = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            MAC: begin
                // One read per cycle; the address runs linearly through the pass.
                if (k_q == K_W'(N_IN - 1)) begin
                    state_d   = DRAIN;
                    w_rd_en_d = 1'b0;
                end else begin
                    k_d      = k_q + K_W'(1);
                    w_addr_d = w_addr_q + W_ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last product lands in the lanes at the end of this cycle.
                state_d = OUT;
                l_d     = '0;
            end
            OUT: begin
                if (!out_valid_q) begin
                    // First cycle of OUT: register lane 0.
                    out_valid_d = 1'b1;
                    out_data_d  = y_lane[l_q];
                    out_idx_d   = idx_of(g_q, l_q);
                end else if (out_ready) begin
                    if (l_q == L_W'(LANES - 1)) begin
                        out_valid_d = 1'b0;
                        if (g_q == B_ADDR_W'(G - 1)) begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = MAC;
                            g_d       = g_q + B_ADDR_W'(1);
                            acc_clear = 1'b1;
                            k_d       = '0;
                            w_rd_en_d = 1'b1;
                            w_addr_d  = w_addr_q + W_ADDR_W'(1);
                        end
                    end else begin
                        l_d        = l_inc;
                        out_data_d = y_lane[l_inc];
                        out_idx_d  = idx_of(g_q, l_inc);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            g_q         <= '0;
            l_q         <= '0;
            k_rd_q      <= '0;
            rd_vld_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                x_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            g_q         <= g_d;
            l_q         <= l_d;
            k_rd_q      <= k_rd_d;
            rd_vld_q    <= rd_vld_d;
            in_ready_q  <= in_ready_d;
            w_rd_en_q   <= w_rd_en_d;
            w_addr_q    <= w_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            x_buf_q     <= x_buf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign w_rd_en   = w_rd_en_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = g_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
